// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM states and op classification helpers for the HI/LO unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'b000,
        MULTU = 3'b001,
        DIV   = 3'b010,
        DIVU  = 3'b011,
        MTHI  = 3'b100,
        MTLO  = 3'b101
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } muldiv_state_t;

    // Signed ops take operand magnitudes and re-apply signs in FIX
    function automatic logic is_signed_op(input muldiv_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic is_div_op(input muldiv_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a dividend bit, trial-subtract the divisor
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             quotient_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // The partial remainder is always below the divisor, so the shifted value
    // stays under 2^(WIDTH+1) and the top bit of the difference is a clean borrow.
    always_comb begin
        shifted      = {rem, dividend_bit};
        diff         = shifted - {2'b00, divisor};
        quotient_bit = ~diff[WIDTH+1];
        rem_next     = quotient_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - iterative multiply/divide unit owning the HI/LO register pair
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import muldiv_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);

    muldiv_state_t      state;
    muldiv_op_t         op_q;
    // Multiplicand for multiplies, divisor for divides
    logic [WIDTH-1:0]   opnd;
    // Multiply: {partial product, multiplier}. Divide: low half is dividend/quotient shifter.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q;
    logic               neg_r;
    logic               dz_q;

    muldiv_op_t         op_in;
    logic               sgn_in;
    logic               neg_a_in;
    logic               neg_b_in;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_next;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem          (rem),
        .dividend_bit (acc[WIDTH-1]),
        .divisor      (opnd),
        .rem_next     (rem_next),
        .quotient_bit (q_bit)
    );

    // Operand decode: signed ops work on magnitudes, signs are remembered for FIX
    always_comb begin
        op_in    = muldiv_op_t'(op);
        sgn_in   = is_signed_op(op_in);
        neg_a_in = sgn_in & a[WIDTH-1];
        neg_b_in = sgn_in & b[WIDTH-1];
        abs_a    = neg_a_in ? -a : a;
        abs_b    = neg_b_in ? -b : b;
    end

    // Shift-add multiply step and sign-corrected results for the FIX edge
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    // Control FSM, datapath registers and HI/LO; done/div_by_zero are single-cycle pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            op_q        <= MULT;
            opnd        <= '0;
            acc         <= '0;
            rem         <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz_q        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op_in)
                            MTHI: hi <= a;
                            MTLO: lo <= a;
                            MULT, MULTU, DIV, DIVU: begin
                                op_q  <= op_in;
                                opnd  <= is_div_op(op_in) ? abs_b : abs_a;
                                acc   <= {{WIDTH{1'b0}}, (is_div_op(op_in) ? abs_a : abs_b)};
                                rem   <= '0;
                                cnt   <= '0;
                                neg_q <= neg_a_in ^ neg_b_in;
                                neg_r <= neg_a_in;
                                dz_q  <= is_div_op(op_in) && (b == '0);
                                state <= RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (is_div_op(op_q)) begin
                        rem              <= rem_next;
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], q_bit};
                    end else begin
                        acc <= mul_next;
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div_op(op_q)) begin
                        lo <= dz_q ? {WIDTH{1'b1}} : quo_fix;
                        hi <= rem_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done        <= 1'b1;
                    div_by_zero <= dz_q;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - scoreboard bench for hilo_muldiv with directed vectors
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input bit push, input logic [31:0] eh, input logic [31:0] el, input logic edz);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        if (push) begin
            e.hi = eh;
            e.lo = el;
            e.dz = edz;
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] eh, input logic [31:0] el, input logic edz);
        int n;
        issue(o, va, vb, 1'b1, eh, el, edz);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        chk("busy_cycles", n, 33);
        chk("done_after_busy", done, 1);
        tick();
    endtask

    // Monitor: every done pulse pops the scoreboard; div_by_zero must stay low otherwise
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", hi, lo);
                end else begin
                    e = sb.pop_front();
                    chk("result_hi", hi, e.hi);
                    chk("result_lo", lo, e.lo);
                    chk("result_dz", div_by_zero, e.dz);
                end
            end else if (reset) begin
                chk("dz_without_done", div_by_zero, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dz", div_by_zero, 0);
        reset = 1'b1;
        tick();

        // Multiplies and divides, including signed cases
        run_op(OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op(OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0);

        // Divide by zero and signed overflow
        run_op(OP_DIV,   32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1);
        run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);

        // MTHI/MTLO on consecutive edges
        issue(OP_MTHI, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("mthi_hi", hi, 32'hDEADBEEF);
        chk("mthi_busy", busy, 0);
        issue(OP_MTLO, 32'h0BADF00D, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("mtlo_lo", lo, 32'h0BADF00D);
        chk("mtlo_hi", hi, 32'hDEADBEEF);
        chk("mtlo_busy", busy, 0);

        // MULTU with an MTHI attempt while busy; hi/lo must hold until done
        issue(OP_MULTU, 32'd3, 32'd5, 1'b1, 32'h0, 32'd15, 1'b0);
        n = 0;
        while (busy && n < 200) begin
            chk("hold_hi", hi, 32'hDEADBEEF);
            chk("hold_lo", lo, 32'h0BADF00D);
            if (n == 5) begin
                start = 1'b1;
                op    = OP_MTHI;
                a     = 32'h11111111;
            end else begin
                start = 1'b0;
            end
            n++;
            tick();
        end
        chk("busy_cycles_hold", n, 33);
        chk("done_hold", done, 1);
        tick();

        // Undefined op code is ignored in IDLE
        start = 1'b1;
        op    = 3'b110;
        a     = 32'hCAFECAFE;
        b     = 32'd1;
        tick();
        start = 1'b0;
        chk("illegal_busy", busy, 0);
        chk("illegal_hi", hi, 0);
        chk("illegal_lo", lo, 15);

        // Reset in the middle of a divide aborts it without a done pulse
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (9) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_done", done, 0);
        repeat (40) tick();
        chk("abort_stays_idle", busy, 0);
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        // Back-to-back: new start accepted in the done cycle
        issue(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h1, 1'b0);
        n = 0;
        while (!done && n < 200) begin
            n++;
            tick();
        end
        chk("b2b_first_done", done, 1);
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd6;
        b     = 32'd7;
        sb.push_back('{hi: 32'h0, lo: 32'd42, dz: 1'b0});
        tick();
        start = 1'b0;
        chk("b2b_accepted", busy, 1);
        n = 1;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk("b2b_done_spacing", n, 34);
        tick();

        repeat (3) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
